ai_bowler_gen: RTL and testbench

Parametrised successor to the single-throw bowler AI: generates paced, randomised bowler throws for the cricket game.
- A configurable-width Fibonacci LFSR runs continuously.
- An internal pacing counter replaces the external throw strobe.
- A difficulty mode selects the throw-range table.
- Throws are presented to the ball/physics logic over a valid/ready handshake; pacing ticks that occur while a throw is still unaccepted are counted.

---
 rtl/ai_bowler_gen.sv | 137 +++++++++++++
 tb/tb_ai_bowler_gen.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ai_bowler_gen.sv
// rtl/ai_bowler_gen.sv - paced, randomised bowler throw generator with valid/ready output
module ai_bowler_gen #(
  parameter int                LFSR_W = 19,
  parameter logic [LFSR_W-1:0] TAPS   = 19'h40023,
  parameter int                SEL_W  = 4,
  parameter int                PERIOD = 50000000,
  parameter int                CNT_W  = 28
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic              game_over,
  input  logic [1:0]        mode,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  output logic              throw_valid,
  input  logic              throw_ready,
  output logic [3:0]        dx,
  output logic [3:0]        dy,
  output logic [SEL_W-1:0]  sel,
  output logic [7:0]        missed
);

  typedef enum logic {IDLE, PRESENT} state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PERIOD - 1);

  state_t             state_q, state_d;
  logic [LFSR_W-1:0]  rand_q, rand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         dx_q, dx_d, dy_q, dy_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [7:0]         missed_q, missed_d;
  logic               tick;
  logic               capture;
  logic [3:0]         s;
  logic [3:0]         dec_dx, dec_dy;

  // A zero seed would lock the LFSR, so it is replaced by all-ones.
  always_comb begin
    if (seed_load) rand_d = (seed == '0) ? '1 : seed;
    else           rand_d = {rand_q[LFSR_W-2:0], ^(rand_q & TAPS)};
  end

  always_comb begin
    tick  = en && !game_over && (cnt_q == '0);
    cnt_d = cnt_q;
    if (game_over)     cnt_d = RELOAD;
    else if (en)       cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
  end

  always_comb begin
    s      = rand_q[3:0];
    dec_dx = 4'd3;
    dec_dy = 4'd2;
    case (mode)
      2'd0: begin
        dec_dy = 4'd1;
        dec_dx = 4'd2 + {3'b000, s[0]};
      end
      2'd2: begin
        dec_dy = 4'd2 + {3'b000, s[0]};
        dec_dx = 4'd3 + {3'b000, s[1]} + {3'b000, s[2]};
      end
      default: begin
        case (s)
          4'd0, 4'd4, 4'd9, 4'd14:  begin dec_dy = 4'd1; dec_dx = 4'd2; end
          4'd5, 4'd12:              begin dec_dy = 4'd2; dec_dx = 4'd2; end
          4'd1, 4'd7, 4'd11, 4'd15: begin dec_dy = 4'd2; dec_dx = 4'd4; end
          default:                  begin dec_dy = 4'd2; dec_dx = 4'd3; end
        endcase
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    sel_d    = sel_q;
    missed_d = missed_q;
    capture  = 1'b0;
    if (game_over) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (tick) begin
            capture = 1'b1;
            state_d = PRESENT;
          end
        end
        default: begin
          // A tick coinciding with acceptance refills the slot back-to-back.
          if (throw_ready) begin
            if (tick) capture = 1'b1;
            else      state_d = IDLE;
          end else if (tick && missed_q != 8'hFF) begin
            missed_d = missed_q + 8'd1;
          end
        end
      endcase
    end
    if (capture) begin
      sel_d = rand_q[SEL_W-1:0];
      dx_d  = dec_dx;
      dy_d  = dec_dy;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rand_q   <= '1;
      cnt_q    <= RELOAD;
      dx_q     <= '0;
      dy_q     <= '0;
      sel_q    <= '0;
      missed_q <= '0;
    end else begin
      state_q  <= state_d;
      rand_q   <= rand_d;
      cnt_q    <= cnt_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      sel_q    <= sel_d;
      missed_q <= missed_d;
    end
  end

  assign throw_valid = (state_q == PRESENT);
  assign dx          = dx_q;
  assign dy          = dy_q;
  assign sel         = sel_q;
  assign missed      = missed_q;

endmodule

// File: tb/tb_ai_bowler_gen.sv
// tb/tb_ai_bowler_gen.sv - directed self-checking bench for ai_bowler_gen
module tb_ai_bowler_gen;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b1;
  logic        game_over = 1'b0;
  logic [1:0]  mode = 2'd1;
  logic        seed_load = 1'b0;
  logic [18:0] seed = '0;
  logic        throw_valid;
  logic        throw_ready = 1'b1;
  logic [3:0]  dx, dy;
  logic [3:0]  sel;
  logic [7:0]  missed;

  int n_checks = 0;
  int n_fail   = 0;

  logic [18:0] model_rand;
  logic [3:0]  exp_sel;
  logic [7:0]  exp_dd;

  ai_bowler_gen #(.LFSR_W(19), .TAPS(19'h40023), .SEL_W(4), .PERIOD(4), .CNT_W(28)) dut (
    .clock(clock), .reset(reset), .en(en), .game_over(game_over), .mode(mode),
    .seed_load(seed_load), .seed(seed), .throw_valid(throw_valid),
    .throw_ready(throw_ready), .dx(dx), .dy(dy), .sel(sel), .missed(missed)
  );

  always #5 clock = ~clock;

  // Reference LFSR built from the polynomial 18,5,1,0.
  always @(posedge clock or negedge reset) begin
    if (!reset)         model_rand <= 19'h7FFFF;
    else if (seed_load) model_rand <= (seed == 19'd0) ? 19'h7FFFF : seed;
    else model_rand <= {model_rand[17:0],
                        model_rand[18] ^ model_rand[5] ^ model_rand[1] ^ model_rand[0]};
  end

  // Returns {dx, dy} for a mode and select value.
  function automatic logic [7:0] exp_decode(input logic [1:0] m, input logic [3:0] s);
    logic [3:0] ex, ey;
    if (m == 2'd0) begin
      ey = 4'd1; ex = s[0] ? 4'd3 : 4'd2;
    end else if (m == 2'd2) begin
      ey = s[0] ? 4'd3 : 4'd2;
      ex = 4'd3 + {3'b000, s[1]} + {3'b000, s[2]};
    end else begin
      case (s)
        4'd0, 4'd4, 4'd9, 4'd14:  begin ex = 4'd2; ey = 4'd1; end
        4'd5, 4'd12:              begin ex = 4'd2; ey = 4'd2; end
        4'd1, 4'd7, 4'd11, 4'd15: begin ex = 4'd4; ey = 4'd2; end
        default:                  begin ex = 4'd3; ey = 4'd2; end
      endcase
    end
    return {ex, ey};
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  // Leaves the bench in cycle 1 after release (before the first active edge).
  task automatic do_reset(input logic [1:0] m, input logic rdy);
    @(negedge clock);
    reset = 1'b0; mode = m; throw_ready = rdy; en = 1'b1;
    game_over = 1'b0; seed_load = 1'b0; seed = '0;
    step(2);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({throw_valid, dx, dy, sel, missed} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%0b dx=%0d dy=%0d sel=%0d missed=%0d required all 0",
               throw_valid, dx, dy, sel, missed);
    end
    n_checks++;
    if (dut.rand_q !== 19'h7FFFF) begin
      n_fail++; $display("FAIL reset_lfsr: got %h required 7ffff", dut.rand_q);
    end
  endtask

  task automatic test_first_throw;
    do_reset(2'd1, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      n_checks++;
      if (throw_valid !== 1'b0) begin
        n_fail++; $display("FAIL first_valid_early: cycle %0d valid=%0b required 0", c, throw_valid);
      end
      if (c == 4) exp_sel = model_rand[3:0];
      else step(1);
    end
    step(1);
    exp_dd = exp_decode(2'd1, exp_sel);
    n_checks++;
    if ({throw_valid, sel, dx, dy} !== {1'b1, exp_sel, exp_dd}) begin
      n_fail++;
      $display("FAIL first_throw: valid=%0b sel=%0d dx=%0d dy=%0d required 1 %0d %0d %0d",
               throw_valid, sel, dx, dy, exp_sel, exp_dd[7:4], exp_dd[3:0]);
    end
    step(1);
    n_checks++;
    if (throw_valid !== 1'b0) begin
      n_fail++; $display("FAIL first_valid_hold: valid=%0b required 0", throw_valid);
    end
  endtask

  task automatic test_lfsr;
    do_reset(2'd1, 1'b1);
    seed_load = 1'b1; seed = 19'd0;
    step(1);
    seed_load = 1'b0;
    n_checks++;
    if (dut.rand_q !== 19'h7FFFF) begin
      n_fail++; $display("FAIL seed_zero: got %h required 7ffff", dut.rand_q);
    end
    seed_load = 1'b1; seed = 19'h00001;
    step(1);
    seed_load = 1'b0;
    n_checks++;
    if (dut.rand_q !== 19'h00001) begin
      n_fail++; $display("FAIL seed_one: got %h required 00001", dut.rand_q);
    end
    for (int i = 0; i < 100; i++) begin
      step(1);
      n_checks++;
      if (dut.rand_q !== model_rand || dut.rand_q == 19'd0) begin
        n_fail++; $display("FAIL lfsr_seq: step %0d got %h required %h", i, dut.rand_q, model_rand);
      end
      if (i == 1) begin
        n_checks++;
        if (dut.rand_q !== 19'h00006) begin
          n_fail++; $display("FAIL lfsr_hand: got %h required 00006", dut.rand_q);
        end
      end
    end
  endtask

  task automatic test_missed;
    do_reset(2'd1, 1'b0);
    step(3);
    exp_sel = model_rand[3:0];
    exp_dd  = exp_decode(2'd1, exp_sel);
    step(37);
    n_checks++;
    if ({throw_valid, sel, dx, dy, missed} !== {1'b1, exp_sel, exp_dd, 8'd9}) begin
      n_fail++;
      $display("FAIL missed_nine: valid=%0b sel=%0d dx=%0d dy=%0d missed=%0d required 1 %0d %0d %0d 9",
               throw_valid, sel, dx, dy, missed, exp_sel, exp_dd[7:4], exp_dd[3:0]);
    end
    step(2000);
    n_checks++;
    if (missed !== 8'd255 || throw_valid !== 1'b1) begin
      n_fail++; $display("FAIL missed_saturate: missed=%0d valid=%0b required 255 1", missed, throw_valid);
    end
  endtask

  task automatic test_mode_sweep;
    logic [7:0] req [3];
    req[0] = {4'd2, 4'd1};
    req[1] = {4'd3, 4'd2};
    req[2] = {4'd5, 4'd2};
    for (int m = 0; m < 3; m++) begin
      do_reset(2'(m), 1'b1);
      step(2);
      seed_load = 1'b1; seed = 19'h00006;
      step(1);
      seed_load = 1'b0;
      step(1);
      n_checks++;
      if ({throw_valid, sel, dx, dy} !== {1'b1, 4'd6, req[m]}) begin
        n_fail++;
        $display("FAIL mode_sweep: mode=%0d valid=%0b sel=%0d dx=%0d dy=%0d required 1 6 %0d %0d",
                 m, throw_valid, sel, dx, dy, req[m][7:4], req[m][3:0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    do_reset(2'd2, 1'b0);
    step(4);
    mode = 2'd0;
    step(4);
    n_checks++;
    if (missed !== 8'd1 || throw_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_pre: missed=%0d valid=%0b required 1 1", missed, throw_valid);
    end
    mode = 2'd2;
    step(3);
    throw_ready = 1'b1;
    exp_sel = model_rand[3:0];
    exp_dd  = exp_decode(2'd2, exp_sel);
    step(1);
    n_checks++;
    if ({throw_valid, sel, dx, dy, missed} !== {1'b1, exp_sel, exp_dd, 8'd1}) begin
      n_fail++;
      $display("FAIL b2b_capture: valid=%0b sel=%0d dx=%0d dy=%0d missed=%0d required 1 %0d %0d %0d 1",
               throw_valid, sel, dx, dy, missed, exp_sel, exp_dd[7:4], exp_dd[3:0]);
    end
    step(1);
    n_checks++;
    if (throw_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drain: valid=%0b required 0", throw_valid);
    end
  endtask

  task automatic test_game_over;
    do_reset(2'd1, 1'b0);
    step(1);
    game_over = 1'b1;
    step(1);
    game_over = 1'b0;
    for (int c = 3; c <= 7; c++) begin
      n_checks++;
      if (throw_valid !== (c == 7)) begin
        n_fail++; $display("FAIL go_midcount: cycle %0d valid=%0b required %0b", c, throw_valid, c == 7);
      end
      if (c < 7) step(1);
    end
    step(4);
    game_over = 1'b1;
    step(1);
    game_over = 1'b0;
    for (int c = 12; c <= 16; c++) begin
      n_checks++;
      if (throw_valid !== (c == 16) || missed !== 8'd1) begin
        n_fail++;
        $display("FAIL go_present: cycle %0d valid=%0b missed=%0d required %0b 1",
                 c, throw_valid, missed, c == 16);
      end
      if (c < 16) step(1);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({throw_valid, dx, dy, sel, missed} !== 21'd0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%0b dx=%0d dy=%0d sel=%0d missed=%0d required all 0",
               throw_valid, dx, dy, sel, missed);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_throw();
    test_lfsr();
    test_missed();
    test_mode_sweep();
    test_back_to_back();
    test_game_over();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
